// File: rtl/boot_seq_ctrl.sv
// boot_seq_ctrl: reset hold, program-load wait, fetch enable and EOC watch.
// Optional run watchdog compiled in with `define BOOT_SEQ_WDOG_EN.
module boot_seq_ctrl #(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned FETCH_DELAY_CYCLES  = 5,
  parameter int unsigned LOAD_TIMEOUT_CYCLES = 1048576,
  parameter logic [31:0] BOOT_ADDR_RST       = 32'h0000_0000,
  parameter int unsigned CNT_W               = 24
`ifdef BOOT_SEQ_WDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES         = 16777215
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode_i,
  input  logic        load_done_i,
  input  logic        boot_addr_we_i,
  input  logic [31:0] boot_addr_wdata_i,
  input  logic        eoc_i,
  output logic        core_rst_no,
  output logic        fetch_enable_o,
  output logic [31:0] boot_addr_o,
  output logic [2:0]  state_o,
  output logic        done_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    S_RESET_HOLD  = 3'd0,
    S_WAIT_LOAD   = 3'd1,
    S_FETCH_DELAY = 3'd2,
    S_RUN         = 3'd3,
    S_DONE        = 3'd4,
    S_TIMEOUT     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] FETCH_LAST =
    CNT_W'(FETCH_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST =
    CNT_W'(LOAD_TIMEOUT_CYCLES - 1);
`ifdef BOOT_SEQ_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST =
    CNT_W'(WDOG_CYCLES - 1);
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               load_seen_q, load_seen_d;
  logic               core_rst_q, core_rst_d;
  logic               fetch_q, fetch_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [31:0]        boot_addr_q;
  logic               eoc_meta, eoc_sync, eoc_prev;
  logic               eoc_rise;
  logic               addr_open;

  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign eoc_rise  = eoc_sync & ~eoc_prev;
  assign addr_open = (state_q == S_RESET_HOLD) |
                     (state_q == S_WAIT_LOAD) |
                     (state_q == S_FETCH_DELAY);

  // Synchronise eoc; prev is zero outside RUN so a high level counts on entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eoc_meta <= 1'b0;
      eoc_sync <= 1'b0;
      eoc_prev <= 1'b0;
    end else begin
      eoc_meta <= eoc_i;
      eoc_sync <= eoc_meta;
      eoc_prev <= (state_q == S_RUN) ? eoc_sync : 1'b0;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET_HOLD;
      cnt_q       <= '0;
      load_seen_q <= 1'b0;
      core_rst_q  <= 1'b0;
      fetch_q     <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_seen_q <= load_seen_d;
      core_rst_q  <= core_rst_d;
      fetch_q     <= fetch_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_seen_d = load_seen_q;
    core_rst_d  = core_rst_q;
    fetch_d     = fetch_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      S_RESET_HOLD: begin
        cnt_d = cnt_inc;
        if (load_done_i) load_seen_d = 1'b1;
        if (cnt_q == HOLD_LAST) begin
          cnt_d      = '0;
          core_rst_d = 1'b1;
          if (mode_i == 2'b00 || load_seen_q)
            state_d = S_FETCH_DELAY;
          else
            state_d = S_WAIT_LOAD;
        end
      end
      S_WAIT_LOAD: begin
        cnt_d = cnt_inc;
        if (load_done_i) load_seen_d = 1'b1;
        if (load_done_i || load_seen_q) begin
          cnt_d   = '0;
          state_d = S_FETCH_DELAY;
        end else if (cnt_q == LOAD_LAST) begin
          state_d    = S_TIMEOUT;
          timeout_d  = 1'b1;
          core_rst_d = 1'b0;
        end
      end
      S_FETCH_DELAY: begin
        cnt_d = cnt_inc;
        if (cnt_q == FETCH_LAST) begin
          cnt_d   = '0;
          fetch_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (eoc_rise) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
`ifdef BOOT_SEQ_WDOG_EN
        else begin
          cnt_d = cnt_inc;
          if (cnt_q == WDOG_LAST) begin
            state_d    = S_TIMEOUT;
            timeout_d  = 1'b1;
            fetch_d    = 1'b0;
            core_rst_d = 1'b0;
          end
        end
`endif
      end
      S_DONE: begin
      end
      S_TIMEOUT: begin
      end
      default: begin
        state_d    = S_TIMEOUT;
        timeout_d  = 1'b1;
        fetch_d    = 1'b0;
        core_rst_d = 1'b0;
      end
    endcase
  end

  // Boot address register, writable until the core starts fetching
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      boot_addr_q <= BOOT_ADDR_RST;
    else if (boot_addr_we_i && addr_open)
      boot_addr_q <= boot_addr_wdata_i;
  end

  assign core_rst_no    = core_rst_q;
  assign fetch_enable_o = fetch_q;
  assign boot_addr_o    = boot_addr_q;
  assign state_o        = state_q;
  assign done_o         = done_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// tb_boot_seq_ctrl: table vectors plus random runs vs. an edge-time model.
// Watchdog vectors follow `define BOOT_SEQ_WDOG_EN.
module tb_boot_seq_ctrl;

  localparam int H = 16;
  localparam int F = 5;
  localparam int T = 128;
  localparam logic [31:0] RST_ADDR = 32'h1A00_0080;
`ifdef BOOT_SEQ_WDOG_EN
  localparam int W = 100;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        load_done = 1'b0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic        eoc = 1'b0;
  logic        core_rst_no;
  logic        fetch_enable_o;
  logic [31:0] boot_addr_o;
  logic [2:0]  state_o;
  logic        done_o;
  logic        timeout_o;

  boot_seq_ctrl #(
    .RST_HOLD_CYCLES(H),
    .FETCH_DELAY_CYCLES(F),
    .LOAD_TIMEOUT_CYCLES(T),
    .BOOT_ADDR_RST(RST_ADDR),
    .CNT_W(24)
`ifdef BOOT_SEQ_WDOG_EN
    ,
    .WDOG_CYCLES(W)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode_i(mode),
    .load_done_i(load_done),
    .boot_addr_we_i(we),
    .boot_addr_wdata_i(wdata),
    .eoc_i(eoc),
    .core_rst_no(core_rst_no),
    .fetch_enable_o(fetch_enable_o),
    .boot_addr_o(boot_addr_o),
    .state_o(state_o),
    .done_o(done_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // lp: edge at which load_done is sampled (0 = none)
  // ee: eoc driven high after edge ee (-1 = never)
  // w1e/w2e: edge at which a write is sampled (0 = none)
  typedef struct {
    logic [1:0]  mode;
    int          lp;
    int          ee;
    int          w1e;
    logic [31:0] w1d;
    int          w2e;
    logic [31:0] w2d;
    int          last;
    int          x_run;
    int          x_done;
    int          x_to;
    logic [31:0] x_addr;
  } vec_t;

  vec_t tbl[13];

  // Model: edge times of each phase, from the sequencing rules
  int m_fd, m_run, m_to, m_term;
  logic [2:0] m_term_st;

  function automatic void plan(input logic [1:0] md,
                               input int lp, input int ee);
    int d;
    m_fd = 0; m_run = 0; m_to = 0; m_term = 0; m_term_st = 3'd0;
    if (md == 2'b00 || (lp > 0 && lp < H)) m_fd = H;
    else if (lp >= H && lp <= H + T) m_fd = (lp > H) ? lp : H + 1;
    else begin
      m_to = H + T;
      return;
    end
    m_run = m_fd + F;
    d = 0;
    if (ee >= 0) d = (ee + 3 > m_run + 1) ? ee + 3 : m_run + 1;
`ifdef BOOT_SEQ_WDOG_EN
    if (d == 0 || d > m_run + W) begin
      m_term = m_run + W;
      m_term_st = 3'd5;
    end else begin
      m_term = d;
      m_term_st = 3'd4;
    end
`else
    if (d != 0) begin
      m_term = d;
      m_term_st = 3'd4;
    end
`endif
  endfunction

  function automatic logic [2:0] xstate(input int e);
    if (e < H) return 3'd0;
    if (m_to != 0) return (e < m_to) ? 3'd1 : 3'd5;
    if (e < m_fd) return 3'd1;
    if (e < m_run) return 3'd2;
    if (m_term != 0 && e >= m_term) return m_term_st;
    return 3'd3;
  endfunction

  function automatic logic [38:0] xbundle(input logic [2:0] s,
                                          input logic [31:0] a);
    return {s, (s != 3'd0 && s != 3'd5), (s == 3'd3 || s == 3'd4),
            (s == 3'd4), (s == 3'd5), a};
  endfunction

  function automatic logic [38:0] got_bundle();
    return {state_o, core_rst_no, fetch_enable_o, done_o, timeout_o,
            boot_addr_o};
  endfunction

  task automatic check(input string nm, input int e,
                       input logic [38:0] got, input logic [38:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %h required %h", nm, e, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int idx,
                           input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d required %0d",
               nm, idx, got, exp);
    end
  endtask

  task automatic run(input vec_t v, output int o_run,
                     output int o_done, output int o_to);
    logic [31:0] xaddr;
    plan(v.mode, v.lp, v.ee);
    o_run = 0; o_done = 0; o_to = 0;
    load_done = 1'b0; we = 1'b0; wdata = '0; eoc = 1'b0;
    mode = v.mode;
    rst_n = 1'b0;
    #2;
    check("reset", 0, got_bundle(), xbundle(3'd0, RST_ADDR));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    xaddr = RST_ADDR;
    for (int e = 1; e <= v.last; e++) begin
      load_done = (e == v.lp);
      we = (e == v.w1e) || (e == v.w2e);
      wdata = (e == v.w2e) ? v.w2d : v.w1d;
      eoc = (v.ee >= 0 && e > v.ee);
      @(posedge clk);
      #1;
      if (we && xstate(e - 1) <= 3'd2) xaddr = wdata;
      check("edge", e, got_bundle(), xbundle(xstate(e), xaddr));
      if (fetch_enable_o && o_run == 0) o_run = e;
      if (done_o && o_done == 0) o_done = e;
      if (timeout_o && o_to == 0) o_to = e;
    end
    load_done = 1'b0; we = 1'b0; eoc = 1'b0;
  endtask

  function automatic vec_t mk(input logic [1:0] md, input int lp,
                              input int ee, input int w1e,
                              input logic [31:0] w1d, input int w2e,
                              input logic [31:0] w2d, input int last,
                              input int xr, input int xd, input int xt,
                              input logic [31:0] xa);
    vec_t v;
    v.mode = md; v.lp = lp; v.ee = ee;
    v.w1e = w1e; v.w1d = w1d; v.w2e = w2e; v.w2d = w2d;
    v.last = last; v.x_run = xr; v.x_done = xd; v.x_to = xt;
    v.x_addr = xa;
    return v;
  endfunction

  initial begin
    int r, d, t;
    vec_t v;
    int wd_to;
`ifdef BOOT_SEQ_WDOG_EN
    wd_to = 21 + W;
`else
    wd_to = 0;
`endif
    tbl[0]  = mk(2'b10, 101, -1, 0, 0, 0, 0, 130, 106, 0, 0, RST_ADDR);
    tbl[1]  = mk(2'b00, 0, 71, 0, 0, 0, 0, 90, 21, 74, 0, RST_ADDR);
    tbl[2]  = mk(2'b10, 6, -1, 0, 0, 0, 0, 40, 21, 0, 0, RST_ADDR);
    tbl[3]  = mk(2'b01, 0, -1, 0, 0, 0, 0, 160, 0, 0, 144, RST_ADDR);
    tbl[4]  = mk(2'b10, 30, -1, 20, 32'h0000_8000, 50, 32'h1234_0000,
                 60, 35, 0, 0, 32'h0000_8000);
    tbl[5]  = mk(2'b00, 0, -1, 21, 32'hDEAD_BEE0, 22, 32'h5555_5555,
                 30, 21, 0, 0, 32'hDEAD_BEE0);
    tbl[6]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 30, 21, 22, 0, RST_ADDR);
    tbl[7]  = mk(2'b11, 144, -1, 0, 0, 0, 0, 160, 149, 0, 0, RST_ADDR);
    tbl[8]  = mk(2'b10, 16, -1, 0, 0, 0, 0, 30, 22, 0, 0, RST_ADDR);
    tbl[9]  = mk(2'b10, 145, -1, 0, 0, 0, 0, 150, 0, 0, 144, RST_ADDR);
    tbl[10] = mk(2'b01, 0, -1, 10, 32'h0000_1000, 145, 32'h0BAD_0000,
                 150, 0, 0, 144, 32'h0000_1000);
    tbl[11] = mk(2'b00, 0, -1, 0, 0, 0, 0, 130, 21, 0, wd_to, RST_ADDR);
    tbl[12] = mk(2'b00, 0, 118, 0, 0, 0, 0, 130, 21, 121, 0, RST_ADDR);

    foreach (tbl[i]) begin
      run(tbl[i], r, d, t);
      check_int("run_edge", i, r, tbl[i].x_run);
      check_int("done_edge", i, d, tbl[i].x_done);
      check_int("timeout_edge", i, t, tbl[i].x_to);
      check_int("final_addr", i, int'(boot_addr_o), int'(tbl[i].x_addr));
    end

    // Asynchronous reset while running, no clock edge in between
    v = mk(2'b00, 0, -1, 5, 32'hCAFE_0000, 0, 0, 30, 21, 0, 0,
           32'hCAFE_0000);
    run(v, r, d, t);
    check_int("pre_reset_fetch", 100, int'(fetch_enable_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 0, got_bundle(), xbundle(3'd0, RST_ADDR));
    @(posedge clk);
    #1;
    check("held_reset", 0, got_bundle(), xbundle(3'd0, RST_ADDR));

    // Randomised runs against the model
    for (int k = 0; k < 40; k++) begin
      v.mode = 2'($urandom_range(0, 3));
      v.lp = ($urandom_range(0, 3) == 0) ? 0 :
             int'($urandom_range(1, H + T + 8));
      v.ee = ($urandom_range(0, 3) == 0) ? -1 :
             int'($urandom_range(0, 200));
      v.w1e = int'($urandom_range(1, 180));
      v.w1d = $urandom;
      v.w2e = int'($urandom_range(1, 180));
      v.w2d = $urandom;
      plan(v.mode, v.lp, v.ee);
      if (m_to != 0) v.last = m_to + 3;
      else if (m_term != 0) v.last = m_term + 3;
      else v.last = m_run + 20;
      run(v, r, d, t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
